// File: rtl/bp_gshare_tracker.sv
// bp_gshare_tracker: gshare 2^IDX_W counter predictor with tag-tracked in-flight branches and GHR repair
module bp_gshare_tracker #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int HIST_W = 4,
  parameter int CTR_INIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [IDX_W-1:0]             lookup_idx,
  output logic                         jump,
  input  logic                         pred_valid,
  input  logic [TAG_W-1:0]             pred_tag,
  input  logic [IDX_W-1:0]             pred_idx,
  input  logic                         pred_taken,
  output logic                         full,
  input  logic                         res_valid,
  input  logic [TAG_W-1:0]             res_tag,
  input  logic                         res_taken,
  output logic                         mis_valid,
  output logic [TAG_W-1:0]             mis_tag,
  input  logic                         flush,
  output logic [HIST_W-1:0]            ghr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NC = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CMAX = '1;
  logic [CTR_W-1:0]  ctr [NC];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  edir;
  logic [TAG_W-1:0]  etag [DEPTH];
  logic [IDX_W-1:0]  ehidx [DEPTH];
  logic [HIST_W-1:0] esnap [DEPTH];
  logic [IDX_W-1:0]  ghr_x;
  logic              hit, free_ok, res_hit, alloc, mis;
  logic [IW-1:0]     hit_i, free_i;
  logic [IDX_W-1:0]  hsel;
  logic [CTR_W-1:0]  cur;
  logic [CW-1:0]     count_nxt;
  assign ghr_x = IDX_W'(ghr);
  assign jump = ctr[lookup_idx ^ ghr_x][CTR_W-1];
  // descending scan so the lowest matching / free index is the last one written
  always_comb begin
    hit = 1'b0;
    hit_i = '0;
    free_ok = 1'b0;
    free_i = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy[i] && etag[i] == res_tag) begin
        hit = 1'b1;
        hit_i = IW'(i);
      end
      if (!busy[i]) begin
        free_ok = 1'b1;
        free_i = IW'(i);
      end
    end
  end
  assign res_hit = res_valid && hit;
  assign alloc = pred_valid && !full && !flush && free_ok;
  assign mis = res_hit && (res_taken != edir[hit_i]);
  assign hsel = ehidx[hit_i];
  assign cur = ctr[hsel];
  assign count_nxt = flush ? '0 : count + CW'(alloc) - CW'(res_hit);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) ctr[i] <= CTR_W'(CTR_INIT);
      busy <= '0;
      ghr <= '0;
      count <= '0;
      full <= 1'b0;
      mis_valid <= 1'b0;
      mis_tag <= '0;
    end else if (rdy) begin
      if (res_hit) begin
        ctr[hsel] <= res_taken ? (cur == CMAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
        busy[hit_i] <= 1'b0;
      end
      if (alloc) begin
        busy[free_i] <= 1'b1;
        etag[free_i] <= pred_tag;
        ehidx[free_i] <= pred_idx ^ ghr_x;
        edir[free_i] <= pred_taken;
        esnap[free_i] <= ghr;
      end
      if (flush) busy <= '0;
      ghr <= mis ? {esnap[hit_i][HIST_W-2:0], res_taken} : alloc ? {ghr[HIST_W-2:0], pred_taken} : ghr;
      count <= count_nxt;
      full <= count_nxt == CW'(DEPTH);
      mis_valid <= mis;
      if (mis) mis_tag <= res_tag;
    end
  end
endmodule

// File: tb/tb_bp_gshare_tracker.sv
// tb_bp_gshare_tracker: directed and randomized checks against a slot-level reference model
module tb_bp_gshare_tracker;
  logic       clk = 0, rst = 1, rdy = 1;
  logic [3:0] lookup_idx = 0, pred_tag = 0, pred_idx = 0, res_tag = 0, mis_tag, ghr;
  logic       pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0, flush = 0;
  logic       jump, full, mis_valid;
  logic [4:0] count;
  int errors = 0, checks = 0;
  int m_ctr [16], m_tag [16], m_hidx [16], m_dir [16], m_snap [16];
  bit m_busy [16];
  int m_ghr, m_count, m_mtag, look, g_saved;
  bit m_full, m_mis;

  bp_gshare_tracker dut (
    .clk(clk), .rst(rst), .rdy(rdy), .lookup_idx(lookup_idx), .jump(jump),
    .pred_valid(pred_valid), .pred_tag(pred_tag), .pred_idx(pred_idx), .pred_taken(pred_taken),
    .full(full), .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .mis_valid(mis_valid), .mis_tag(mis_tag), .flush(flush), .ghr(ghr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", n, o, e);
    end
  endtask

  task automatic model_step();
    int h, f, g0, c;
    bit al, mis;
    if (!rdy) return;
    h = -1;
    f = -1;
    g0 = m_ghr;
    for (int i = 15; i >= 0; i--) begin
      if (m_busy[i] && res_valid && m_tag[i] == int'(res_tag)) h = i;
      if (!m_busy[i]) f = i;
    end
    al = pred_valid && !m_full && !flush;
    mis = (h >= 0) && (m_dir[h] != int'(res_taken));
    if (h >= 0) begin
      c = m_ctr[m_hidx[h]];
      m_ctr[m_hidx[h]] = res_taken ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
      m_busy[h] = 0;
    end
    if (mis) m_ghr = ((m_snap[h] << 1) | int'(res_taken)) & 15;
    else if (al) m_ghr = ((g0 << 1) | int'(pred_taken)) & 15;
    if (al) begin
      m_busy[f] = 1;
      m_tag[f] = int'(pred_tag);
      m_hidx[f] = int'(pred_idx) ^ g0;
      m_dir[f] = int'(pred_taken);
      m_snap[f] = g0;
    end
    if (flush) for (int i = 0; i < 16; i++) m_busy[i] = 0;
    m_count = 0;
    for (int i = 0; i < 16; i++) m_count += int'(m_busy[i]);
    m_full = m_count == 16;
    m_mis = mis;
    if (mis) m_mtag = int'(res_tag);
  endtask

  task automatic check_regs();
    chk("count", count, m_count);
    chk("full", full, m_full);
    chk("ghr", ghr, m_ghr);
    chk("mis_valid", mis_valid, m_mis);
    chk("mis_tag", mis_tag, m_mtag);
  endtask

  task automatic tick();
    lookup_idx = 4'(look ^ m_ghr);
    #1 chk("jump", jump, m_ctr[look] >= 2);
    @(posedge clk);
    model_step();
    #1 check_regs();
  endtask

  task automatic clear();
    pred_valid = 0;
    res_valid = 0;
    flush = 0;
  endtask

  task automatic alloc(input int t, input int i, input bit d);
    pred_valid = 1; pred_tag = 4'(t); pred_idx = 4'(i); pred_taken = d;
    tick();
    clear();
  endtask

  task automatic resolve(input int t, input bit d);
    res_valid = 1; res_tag = 4'(t); res_taken = d;
    tick();
    clear();
  endtask

  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 16; i++) begin m_ctr[i] = 1; m_busy[i] = 0; end
    m_ghr = 0; m_count = 0; m_full = 0; m_mis = 0; m_mtag = 0;
    check_regs();
    // train counter 3 with one mispredict
    look = 3;
    alloc(5, 3, 0);
    resolve(5, 1);
    chk("tp_mis_valid", mis_valid, 1);
    chk("tp_mis_tag", mis_tag, 5);
    chk("tp_ghr", ghr, 1);
    lookup_idx = 2;
    #1 chk("tp_jump_trained", jump, 1);
    // saturation at both ends
    repeat (2) begin alloc(5, 3 ^ m_ghr, 1); resolve(5, 1); end
    repeat (5) begin alloc(5, 3 ^ m_ghr, 0); resolve(5, 0); end
    alloc(5, 3 ^ m_ghr, 1);
    resolve(5, 1);
    lookup_idx = 4'(3 ^ m_ghr);
    #1 chk("tp_no_wrap", jump, 0);
    // fill to capacity
    flush = 1; tick(); clear();
    for (int t = 0; t < 16; t++) alloc(t, t, 0);
    chk("tp_full", full, 1);
    chk("tp_count16", count, 16);
    alloc(7, 1, 1);
    chk("tp_drop", count, 16);
    resolve(0, 0);
    chk("tp_count15", count, 15);
    chk("tp_notfull", full, 0);
    chk("tp_no_mis", mis_valid, 0);
    // GHR repair from snapshot
    flush = 1; tick(); clear();
    alloc(1, 0, 1);
    alloc(2, 0, 0);
    alloc(3, 0, 1);
    chk("tp_ghr0101", ghr, 4'b0101);
    resolve(2, 1);
    chk("tp_ghr_repair", ghr, 4'b0011);
    chk("tp_repair_tag", mis_tag, 2);
    // flush with simultaneous allocate
    alloc(4, 1, 0);
    alloc(6, 2, 1);
    chk("tp_count4", count, 4);
    g_saved = m_ghr;
    flush = 1; pred_valid = 1; pred_tag = 7; pred_idx = 1; pred_taken = 1;
    tick(); clear();
    chk("tp_flush_count", count, 0);
    chk("tp_flush_ghr", ghr, g_saved);
    resolve(1, 0);
    chk("tp_stale_mis", mis_valid, 0);
    chk("tp_stale_count", count, 0);
    // stall during a mispredicting resolve
    alloc(8, 5, 0);
    rdy = 0; res_valid = 1; res_tag = 8; res_taken = 1;
    repeat (3) begin
      tick();
      chk("tp_stall_mis", mis_valid, 0);
      chk("tp_stall_count", count, 1);
    end
    rdy = 1;
    tick(); clear();
    chk("tp_stall_pulse", mis_valid, 1);
    chk("tp_stall_tag", mis_tag, 8);
    tick();
    chk("tp_pulse_end", mis_valid, 0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      look = $urandom_range(0, 15);
      rdy = ($urandom % 8) != 0;
      pred_valid = ($urandom % 3) != 0;
      pred_tag = 4'($urandom);
      pred_idx = 4'($urandom);
      pred_taken = 1'($urandom);
      res_valid = ($urandom % 2) != 0;
      res_tag = 4'($urandom);
      res_taken = 1'($urandom);
      flush = ($urandom % 25) == 0;
      tick();
    end
    clear();
    rdy = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
